fetch_stage: RTL

- IF stage of the 5-stage RV32I pipeline.
- Holds the PC, reads instruction memory, and predicts the next PC with a direct-mapped BTB plus 2-bit saturating counters.
- Drives the IF/ID register, including the prediction_valid and predicted_pc that the execute stage checks for mispredictions.
- Takes the pc_redirect/flush and branch-resolution signals back from the execute stage to correct the PC and train the predictor.

---
 rtl/fetch_stage_if.sv | 15 +
 rtl/fetch_stage.sv | 80 ++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: pipeline-side bus of the IF stage (control, execute feedback, imem, IF/ID)
interface fetch_stage_if;
  logic i_stall, i_pc_redirect, i_ex_update, i_ex_is_cond, i_ex_taken;
  logic [31:0] i_ex_pc, i_ex_target, i_imem_rdata;
  logic o_if_id_valid, o_if_id_pred_valid;
  logic [31:0] o_imem_addr, o_if_id_pc, o_if_id_instr, o_if_id_pred_pc;
  modport master (
    output i_stall, i_pc_redirect, i_ex_update, i_ex_is_cond, i_ex_taken, i_ex_pc, i_ex_target, i_imem_rdata,
    input o_if_id_valid, o_if_id_pred_valid, o_imem_addr, o_if_id_pc, o_if_id_instr, o_if_id_pred_pc
  );
  modport slave (
    input i_stall, i_pc_redirect, i_ex_update, i_ex_is_cond, i_ex_taken, i_ex_pc, i_ex_target, i_imem_rdata,
    output o_if_id_valid, o_if_id_pred_valid, o_imem_addr, o_if_id_pc, o_if_id_instr, o_if_id_pred_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage with PC, direct-mapped BTB + 2-bit counters, and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic clk,
  input logic rst,
  fetch_stage_if.slave bus
);
  localparam int N  = 1 << BTB_IDX_W;
  localparam int TW = 30 - BTB_IDX_W;
  logic [31:0] r_pc, r_if_id_pc, r_if_id_instr, r_if_id_pred_pc;
  logic r_if_id_valid, r_if_id_pred_valid;
  logic [N-1:0] r_btb_v;
  logic [TW-1:0] r_btb_tag [N];
  logic [31:0] r_btb_tgt [N];
  logic [1:0] r_btb_ctr [N];
  logic [BTB_IDX_W-1:0] w_idx, w_uidx;
  logic w_hit, w_pred, w_uhit, w_utaken;
  logic [31:0] w_next;
  always_comb begin
    w_idx    = r_pc[BTB_IDX_W+1:2];
    w_hit    = r_btb_v[w_idx] && r_btb_tag[w_idx] == r_pc[31:BTB_IDX_W+2];
    w_pred   = w_hit && r_btb_ctr[w_idx][1];
    w_next   = w_pred ? r_btb_tgt[w_idx] : r_pc + 32'd4;
    w_uidx   = bus.i_ex_pc[BTB_IDX_W+1:2];
    w_uhit   = r_btb_v[w_uidx] && r_btb_tag[w_uidx] == bus.i_ex_pc[31:BTB_IDX_W+2];
    w_utaken = bus.i_ex_taken || !bus.i_ex_is_cond;
  end
  assign bus.o_imem_addr        = r_pc;
  assign bus.o_if_id_valid      = r_if_id_valid;
  assign bus.o_if_id_pc         = r_if_id_pc;
  assign bus.o_if_id_instr      = r_if_id_instr;
  assign bus.o_if_id_pred_valid = r_if_id_pred_valid;
  assign bus.o_if_id_pred_pc    = r_if_id_pred_pc;
  // redirect beats stall: the wrong-path slot must be squashed even while held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc               <= RESET_PC;
      r_if_id_valid      <= 1'b0;
      r_if_id_pc         <= 32'd0;
      r_if_id_instr      <= NOP_INSTR;
      r_if_id_pred_valid <= 1'b0;
      r_if_id_pred_pc    <= 32'd0;
    end else if (bus.i_pc_redirect) begin
      r_pc               <= bus.i_ex_taken ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
      r_if_id_valid      <= 1'b0;
      r_if_id_instr      <= NOP_INSTR;
      r_if_id_pred_valid <= 1'b0;
    end else if (!bus.i_stall) begin
      r_pc               <= w_next;
      r_if_id_valid      <= 1'b1;
      r_if_id_pc         <= r_pc;
      r_if_id_instr      <= bus.i_imem_rdata;
      r_if_id_pred_valid <= w_pred;
      r_if_id_pred_pc    <= w_next;
    end
  end
  // training writes land after the edge, so same-cycle lookups see old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_btb_v[k]   <= 1'b0;
        r_btb_ctr[k] <= 2'b01;
      end
    end else if (bus.i_ex_update) begin
      if (w_uhit) begin
        r_btb_ctr[w_uidx] <= w_utaken ? (r_btb_ctr[w_uidx] == 2'b11 ? 2'b11 : r_btb_ctr[w_uidx] + 2'd1)
                                      : (r_btb_ctr[w_uidx] == 2'b00 ? 2'b00 : r_btb_ctr[w_uidx] - 2'd1);
        if (w_utaken) r_btb_tgt[w_uidx] <= bus.i_ex_target;
      end else if (w_utaken) begin
        r_btb_v[w_uidx]   <= 1'b1;
        r_btb_tag[w_uidx] <= bus.i_ex_pc[31:BTB_IDX_W+2];
        r_btb_tgt[w_uidx] <= bus.i_ex_target;
        r_btb_ctr[w_uidx] <= 2'b10;
      end
    end
  end
endmodule
